// File: rtl/tespar_pkg.sv
// Shared TESPAR alphabet constants and the (D,S) -> symbol map.
// Used by the stream encoder and the downstream histogram stage.
package tespar_pkg;

    localparam int SYM_W        = 5;
    localparam int SYM_OVERLONG = 31;

    localparam int BAND1_LIM  = 8;
    localparam int BAND2_LIM  = 16;
    localparam int BAND3_LIM  = 24;
    localparam int BAND1_BASE = 8;
    localparam int BAND2_BASE = 14;
    localparam int BAND3_BASE = 20;

    typedef enum logic {
        EP_IDLE = 1'b0,
        EP_OPEN = 1'b1
    } ep_state_t;

    // Short epochs encode duration only; longer epochs pick a band by D and offset by S.
    function automatic logic [SYM_W-1:0] tespar_map(input int d, input int s, input int max_d);
        int v;
        if (d >= max_d)
            v = SYM_OVERLONG;
        else if (d <= 0)
            v = 0;
        else if (d <= BAND1_LIM)
            v = d - 1;
        else if (d <= BAND2_LIM)
            v = BAND1_BASE + s;
        else if (d <= BAND3_LIM)
            v = BAND2_BASE + s;
        else
            v = BAND3_BASE + s;
        return v[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/tespar_sym_fifo.sv
// Generic synchronous FIFO with occupancy count and full/empty flags.
// Head data reads as zero while empty; pushes are refused when full unless a pop frees a slot.
module tespar_sym_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/tespar_stream_encoder.sv
// Streaming TESPAR encoder: splits signed samples into constant-sign epochs,
// measures duration/shape, maps to a symbol and queues {symbol,D,S} for the consumer.
module tespar_stream_encoder
    import tespar_pkg::*;
#(
    parameter int DW         = 8,
    parameter int MAX_D      = 37,
    parameter int S_MAX      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic signed [DW-1:0]            data_in,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SYM_W-1:0]                symbol_out,
    output logic [$clog2(MAX_D+1)-1:0]      out_d,
    output logic [$clog2(S_MAX+1)-1:0]      out_s,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow
);

    // state   | meaning
    // EP_IDLE | no epoch open, next accepted sample starts one
    // EP_OPEN | epoch open, accumulating D and S

    localparam int DWID = $clog2(MAX_D+1);
    localparam int SWID = $clog2(S_MAX+1);
    localparam int EW   = SYM_W + DWID + SWID;
    localparam logic [DWID-1:0] D_SAT = DWID'(MAX_D);
    localparam logic [SWID-1:0] S_SAT = SWID'(S_MAX);

    ep_state_t          r_state;
    ep_state_t          w_state_nxt;
    logic [DWID-1:0]    r_d;
    logic [SWID-1:0]    r_s;
    logic               r_falling;
    logic               r_neg;
    logic [DW:0]        r_prev_mag;
    logic               r_overflow;

    logic               w_accept;
    logic               w_neg;
    logic signed [DW:0] w_ext;
    logic [DW:0]        w_mag;
    logic               w_push;
    logic               w_open;
    logic               w_extend;
    logic               w_close_only;
    logic [SYM_W-1:0]   w_sym;
    logic [EW-1:0]      w_entry;
    logic [EW-1:0]      w_head;
    logic               w_full;
    logic               w_empty;

    assign w_accept = in_valid && !flush;
    assign w_neg    = data_in[DW-1];
    assign w_ext    = data_in;
    // One extra bit so the most negative sample has a representable magnitude.
    assign w_mag    = w_neg ? $unsigned(-w_ext) : $unsigned(w_ext);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= EP_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EP_IDLE: if (w_accept) w_state_nxt = EP_OPEN;
            EP_OPEN: if (flush)    w_state_nxt = EP_IDLE;
            default:               w_state_nxt = EP_IDLE;
        endcase
    end

    always_comb begin
        w_push       = 1'b0;
        w_open       = 1'b0;
        w_extend     = 1'b0;
        w_close_only = 1'b0;
        case (r_state)
            EP_IDLE: w_open = w_accept;
            EP_OPEN: begin
                if (flush) begin
                    w_push       = 1'b1;
                    w_close_only = 1'b1;
                end else if (w_accept) begin
                    if (w_neg != r_neg) begin
                        w_push = 1'b1;
                        w_open = 1'b1;
                    end else begin
                        w_extend = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d        <= '0;
            r_s        <= '0;
            r_falling  <= 1'b0;
            r_neg      <= 1'b0;
            r_prev_mag <= '0;
        end else if (w_open) begin
            r_d        <= DWID'(1);
            r_s        <= '0;
            r_falling  <= 1'b0;
            r_neg      <= w_neg;
            r_prev_mag <= w_mag;
        end else if (w_close_only) begin
            r_d       <= '0;
            r_s       <= '0;
            r_falling <= 1'b0;
        end else if (w_extend) begin
            if (r_d != D_SAT)
                r_d <= r_d + 1'b1;
            if (w_mag < r_prev_mag) begin
                r_falling <= 1'b1;
            end else if (w_mag > r_prev_mag && r_falling) begin
                if (r_s != S_SAT)
                    r_s <= r_s + 1'b1;
                r_falling <= 1'b0;
            end
            r_prev_mag <= w_mag;
        end
    end

    assign w_sym   = tespar_map(32'(r_d), 32'(r_s), MAX_D);
    assign w_entry = {w_sym, r_d, r_s};

    tespar_sym_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_count (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // When full, a pop is possible exactly when out_ready is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !out_ready)
            r_overflow <= 1'b1;
    end

    assign out_valid                   = !w_empty;
    assign {symbol_out, out_d, out_s}  = w_head;
    assign overflow                    = r_overflow;

endmodule
